// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment lookup for the multiplexed 7-segment driver.
package seg_pkg;

    localparam int          DIG_NUM = 6;
    localparam logic [5:0]  SEL_OFF = 6'h3F;
    localparam logic [7:0]  SEG_OFF = 8'hFF;

    // Active-high gfedcba pattern for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational nibble to active-high gfedcba segment pattern.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = hex7(nib);

endmodule

// File: rtl/seg_scan_drv.sv
// Six-digit common-anode display scanner with frame-synchronous commit of host writes.
// Define SEG_LZB_EN to blank leading zeros (digit 0 always shown).
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLANK_CYC = 500
) (
    input  logic        CLK_50M,
    input  logic        RST_n,
    input  logic        wr_en,
    input  logic [23:0] wr_data,
    input  logic [5:0]  wr_dp,
    output logic        pend,
    output logic        frame_done,
    output logic [5:0]  SEL,
    output logic [7:0]  SEG
);

    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_MAX   = 3'(DIG_NUM - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [23:0]      shadow_data;
    logic [5:0]       shadow_dp;
    logic [23:0]      active_data;
    logic [5:0]       active_dp;

    logic             slot_wrap;
    logic             frame_edge;
    logic [3:0]       nib_p0;
    logic [6:0]       pat_p0;
    logic             lz_blank_p0;
    logic [6:0]       seg7_p0;

    assign slot_wrap  = (cnt == CNT_MAX);
    assign frame_edge = slot_wrap && (idx == IDX_MAX);

    assign nib_p0 = active_data[{idx, 2'b00} +: 4];

    seg_hex_dec u_hex_dec (
        .nib (nib_p0),
        .pat (pat_p0)
    );

`ifdef SEG_LZB_EN
    logic [2:0] lz_top;

    // Highest non-zero digit; everything above it is a leading zero
    always_comb begin
        lz_top = '0;
        for (int i = 1; i < DIG_NUM; i++) begin
            if (active_data[i*4 +: 4] != 4'h0) lz_top = 3'(i);
        end
    end

    assign lz_blank_p0 = (idx > lz_top);
`else
    assign lz_blank_p0 = 1'b0;
`endif

    assign seg7_p0 = lz_blank_p0 ? 7'h7F : ~pat_p0;

    // Scan divider and digit index
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow/active registers; the commit reads the shadow as it was before this edge
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
            pend        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_edge;
            if (frame_edge && pend) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
            end
            if (wr_en) begin
                shadow_data <= wr_data;
                shadow_dp   <= wr_dp;
                pend        <= 1'b1;
            end else if (frame_edge) begin
                pend <= 1'b0;
            end
        end
    end

    // Registered pin drivers, one cycle behind cnt/idx
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            SEL <= SEL_OFF;
            SEG <= SEG_OFF;
        end else if (cnt < BLANK_END) begin
            SEL <= SEL_OFF;
            SEG <= SEG_OFF;
        end else begin
            SEL <= ~(6'b1 << idx);
            SEG <= {~active_dp[idx], seg7_p0};
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed scoreboard bench for seg_scan_drv with a short scan period.
module tb_seg_scan_drv;

    logic        CLK_50M = 1'b0;
    logic        RST_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [23:0] wr_data = '0;
    logic [5:0]  wr_dp   = '0;
    logic        pend;
    logic        frame_done;
    logic [5:0]  SEL;
    logic [7:0]  SEG;

    int checks   = 0;
    int failures = 0;

    logic [13:0] sb[$];

    seg_scan_drv #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .CLK_50M    (CLK_50M),
        .RST_n      (RST_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .pend       (pend),
        .frame_done (frame_done),
        .SEL        (SEL),
        .SEG        (SEG)
    );

    always #10 CLK_50M = ~CLK_50M;

    function automatic logic [7:0] model_seg(input logic [23:0] data, input logic [5:0] dp, input int d);
        logic [3:0] n;
        logic [6:0] p;
        n = data[d*4 +: 4];
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        p = ~p;
`ifdef SEG_LZB_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < 6; i++) if (data[i*4 +: 4] != 4'h0) top = i;
            if (d > top) p = 7'h7F;
        end
`endif
        return {~dp[d], p};
    endfunction

    task automatic push_frame(input logic [23:0] data, input logic [5:0] dp);
        logic [5:0] s;
        for (int d = 0; d < 6; d++) begin
            s = 6'b1 << d;
            sb.push_back({~s, model_seg(data, dp, d)});
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_write(input logic [23:0] data, input logic [5:0] dp);
        wr_data = data;
        wr_dp   = dp;
        wr_en   = 1'b1;
        @(posedge CLK_50M); #1;
        wr_en   = 1'b0;
    endtask

    // Waits for the next boundary pulse, then checks one whole frame against the queue
    task automatic check_frame(input string tag);
        int n;
        logic [13:0] e;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(posedge CLK_50M); #1;
            n++;
        end
        chk({tag, "_frame_done"}, {15'd0, frame_done}, 16'd1);
        for (int d = 0; d < 6; d++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 14'h0;
            @(posedge CLK_50M); #1;
            chk($sformatf("%s_d%0d_blank0", tag, d), {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
            if (d == 0) chk({tag, "_fd_pulse"}, {15'd0, frame_done}, 16'd0);
            @(posedge CLK_50M); #1;
            chk($sformatf("%s_d%0d_blank1", tag, d), {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
            @(posedge CLK_50M); #1;
            chk($sformatf("%s_d%0d_lit", tag, d), {2'b0, SEL, SEG}, {2'b0, e});
            repeat (5) @(posedge CLK_50M);
        end
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK_50M);
        #1;
        chk("rst_sel_seg", {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
        chk("rst_pend", {15'd0, pend}, 16'd0);
        chk("rst_fd", {15'd0, frame_done}, 16'd0);
        RST_n = 1'b1;
        @(posedge CLK_50M); #1;
        chk("rel_blank0", {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
        @(posedge CLK_50M); #1;
        chk("rel_blank1", {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
        @(posedge CLK_50M); #1;
        chk("rel_first_lit", {2'b0, SEL, SEG}, {2'b0, 6'h3E, 8'hC0});

        // Mid-frame write is held until the boundary
        drive_write(24'h123456, 6'h00);
        chk("wr_pend", {15'd0, pend}, 16'd1);
        chk("wr_display_held", {2'b0, SEL, SEG}, {2'b0, 6'h3E, 8'hC0});
        push_frame(24'h123456, 6'h00);
        check_frame("f123456");
        chk("f123456_pend_clr", {15'd0, pend}, 16'd0);

        // Two writes in one frame: last wins
        drive_write(24'h000001, 6'h00);
        drive_write(24'h00000A, 6'h00);
        chk("dbl_pend", {15'd0, pend}, 16'd1);
        push_frame(24'h00000A, 6'h00);
        check_frame("fA");

        // Write landing exactly on the boundary edge
        drive_write(24'h000002, 6'h00);
        repeat (46) @(posedge CLK_50M);
        #1;
        wr_data = 24'h000003;
        wr_dp   = 6'h00;
        wr_en   = 1'b1;
        @(posedge CLK_50M); #1;
        wr_en   = 1'b0;
        chk("bnd_fd_aligned", {15'd0, frame_done}, 16'd1);
        chk("bnd_pend_kept", {15'd0, pend}, 16'd1);
        push_frame(24'h000002, 6'h00);
        push_frame(24'h000003, 6'h00);
        check_frame("bnd_old");
        check_frame("bnd_new");
        chk("bnd_pend_clr", {15'd0, pend}, 16'd0);

        // Decimal point on digit 0
        drive_write(24'h000000, 6'b000001);
        push_frame(24'h000000, 6'b000001);
        check_frame("dp0");

        // Mixed zeros (leading-zero blanking case when enabled)
        drive_write(24'h000507, 6'h00);
        push_frame(24'h000507, 6'h00);
        check_frame("f507");

        // Reset mid-frame drops the pending write
        drive_write(24'h000009, 6'h00);
        repeat (10) @(posedge CLK_50M);
        #1;
        RST_n = 1'b0;
        #1;
        chk("mrst_sel_seg", {2'b0, SEL, SEG}, {2'b0, 6'h3F, 8'hFF});
        chk("mrst_pend", {15'd0, pend}, 16'd0);
        @(posedge CLK_50M); #1;
        RST_n = 1'b1;
        repeat (3) @(posedge CLK_50M);
        #1;
        chk("mrst_first_lit", {2'b0, SEL, SEG}, {2'b0, 6'h3E, 8'hC0});
        push_frame(24'h000000, 6'h00);
        check_frame("mrst_zero");
        chk("mrst_pend_end", {15'd0, pend}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
